// File: rtl/tmr_seq_pkg.sv
// Shared types and constants for the timer control sequencer.
// Register map, control/status bit positions, state encodings, error codes.
package tmr_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_TDR,
        S_WR_TCR_LD,
        S_WR_TCR_EN,
        S_GAP,
        S_RD_TSR,
        S_CLR_TSR,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_ACCESS
    } xfer_e;

    localparam logic [7:0] OFF_TDR = 8'h00;
    localparam logic [7:0] OFF_TCR = 8'h01;
    localparam logic [7:0] OFF_TSR = 8'h02;

    localparam int TCR_LOAD_BIT = 7;
    localparam int TCR_EN_BIT   = 4;
    localparam int TSR_OVF_BIT  = 0;

    localparam logic [7:0] TCR_LOAD = 8'(1 << TCR_LOAD_BIT);
    localparam logic [7:0] TCR_EN   = 8'(1 << TCR_EN_BIT);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_SLVERR  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/tmr_apb_xfer.sv
// Single APB transfer engine: one SETUP cycle, then ACCESS until PREADY.
// Request fields are latched on acceptance so the bus stays stable.
module tmr_apb_xfer
    import tmr_seq_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    input  logic          write_i,
    output logic          ack_o,
    output logic [7:0]    rdata_o,
    output logic          slverr_o,
    output logic          idle_o,
    output logic          psel_o,
    output logic          penable_o,
    output logic          pwrite_o,
    output logic [AW-1:0] paddr_o,
    output logic [31:0]   pwdata_o,
    input  logic          pready_i,
    input  logic [7:0]    prdata_i,
    input  logic          pslverr_i
);

    xfer_e         st_q, st_d;
    logic [AW-1:0] addr_q;
    logic [7:0]    wdata_q;
    logic          write_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q    <= X_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            st_q <= st_d;
            if (st_q == X_IDLE && req_i) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                write_q <= write_i;
            end
        end
    end

    always_comb begin
        st_d  = st_q;
        ack_o = 1'b0;
        unique case (st_q)
            X_IDLE:   if (req_i) st_d = X_SETUP;
            X_SETUP:  st_d = X_ACCESS;
            X_ACCESS: begin
                if (pready_i) begin
                    st_d  = X_IDLE;
                    ack_o = 1'b1;
                end
            end
            default:  st_d = X_IDLE;
        endcase
    end

    assign slverr_o  = ack_o & pslverr_i;
    assign rdata_o   = prdata_i;
    assign idle_o    = (st_q == X_IDLE);
    assign psel_o    = (st_q != X_IDLE);
    assign penable_o = (st_q == X_ACCESS);
    assign pwrite_o  = write_q;
    assign paddr_o   = addr_q;
    assign pwdata_o  = {24'h0, wdata_q};

endmodule

// File: rtl/timer_ctrl_seq.sv
// Timer bring-up sequencer: load TDR, load+enable via TCR, poll TSR, clear.
// Optional poll timeout enabled by defining TMR_SEQ_TIMEOUT_EN.
module timer_ctrl_seq
    import tmr_seq_pkg::*;
#(
    parameter int                        APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] TIMER_BASE     = 12'h000,
    parameter int                        POLL_GAP       = 8,
    parameter logic [15:0]               MAX_POLLS      = 16'd1024
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      start,
    input  logic [7:0]                init_value,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      ovf_seen,
    output logic [1:0]                err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    input  logic [7:0]                PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

    if (POLL_GAP < 1 || POLL_GAP > 255 || MAX_POLLS == 16'd0) begin : g_bad_param
        $error("timer_ctrl_seq: POLL_GAP or MAX_POLLS out of range");
    end

    state_e     state_q, state_d;
    logic [7:0] tdr_q, tdr_d;
    logic [7:0] gap_q, gap_d;
    logic       ovf_q, ovf_d;
    logic [1:0] err_q, err_d;

    logic       is_xfer;
    logic       x_req, x_write, x_ack, x_slverr, x_idle;
    logic [7:0] x_off, x_wdata, x_rdata;
    logic       unused_rdata;

`ifdef TMR_SEQ_TIMEOUT_EN
    logic [15:0] poll_q, poll_d;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= S_IDLE;
            tdr_q   <= '0;
            gap_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= ERR_OK;
`ifdef TMR_SEQ_TIMEOUT_EN
            poll_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            tdr_q   <= tdr_d;
            gap_q   <= gap_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
`ifdef TMR_SEQ_TIMEOUT_EN
            poll_q  <= poll_d;
`endif
        end
    end

    // GAP presets the TSR read so its last idle cycle issues the request
    always_comb begin
        is_xfer = 1'b1;
        x_off   = OFF_TDR;
        x_wdata = '0;
        x_write = 1'b1;
        unique case (state_q)
            S_WR_TDR:    x_wdata = tdr_q;
            S_WR_TCR_LD: begin
                x_off   = OFF_TCR;
                x_wdata = TCR_LOAD;
            end
            S_WR_TCR_EN: begin
                x_off   = OFF_TCR;
                x_wdata = TCR_EN;
            end
            S_RD_TSR: begin
                x_off   = OFF_TSR;
                x_write = 1'b0;
            end
            S_GAP: begin
                is_xfer = 1'b0;
                x_off   = OFF_TSR;
                x_write = 1'b0;
            end
            S_CLR_TSR:   x_off = OFF_TSR;
            default:     is_xfer = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tdr_d   = tdr_q;
        gap_d   = gap_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        x_req   = 1'b0;
`ifdef TMR_SEQ_TIMEOUT_EN
        poll_d  = poll_q;
`endif
        if (is_xfer) begin
            if (x_idle) begin
                if (abort) state_d = S_IDLE;
                else       x_req   = 1'b1;
            end else if (x_ack) begin
                if (state_q == S_RD_TSR && !x_slverr && x_rdata[TSR_OVF_BIT])
                    ovf_d = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (x_slverr) begin
                    state_d = S_DONE;
                    err_d   = ERR_SLVERR;
                end else begin
                    unique case (state_q)
                        S_WR_TDR:    state_d = S_WR_TCR_LD;
                        S_WR_TCR_LD: state_d = S_WR_TCR_EN;
                        S_WR_TCR_EN: begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end
                        S_RD_TSR: begin
                            if (x_rdata[TSR_OVF_BIT]) begin
                                state_d = S_CLR_TSR;
                            end else begin
`ifdef TMR_SEQ_TIMEOUT_EN
                                poll_d = poll_q + 16'd1;
                                if (poll_d >= MAX_POLLS) begin
                                    state_d = S_DONE;
                                    err_d   = ERR_TIMEOUT;
                                end else begin
                                    state_d = S_GAP;
                                    gap_d   = '0;
                                end
`else
                                state_d = S_GAP;
                                gap_d   = '0;
`endif
                            end
                        end
                        S_CLR_TSR: begin
                            state_d = S_DONE;
                            err_d   = ERR_OK;
                        end
                        default: ;
                    endcase
                end
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_WR_TDR;
                        tdr_d   = init_value;
                        ovf_d   = 1'b0;
                        err_d   = ERR_OK;
`ifdef TMR_SEQ_TIMEOUT_EN
                        poll_d  = '0;
`endif
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state_d = S_IDLE;
                    end else if (gap_q == GAP_LAST) begin
                        x_req   = 1'b1;
                        state_d = S_RD_TSR;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: ;
            endcase
        end
    end

    tmr_apb_xfer #(
        .AW(APB_ADDR_WIDTH)
    ) u_xfer (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .req_i     (x_req),
        .addr_i    (TIMER_BASE + APB_ADDR_WIDTH'(x_off)),
        .wdata_i   (x_wdata),
        .write_i   (x_write),
        .ack_o     (x_ack),
        .rdata_o   (x_rdata),
        .slverr_o  (x_slverr),
        .idle_o    (x_idle),
        .psel_o    (PSEL),
        .penable_o (PENABLE),
        .pwrite_o  (PWRITE),
        .paddr_o   (PADDR),
        .pwdata_o  (PWDATA),
        .pready_i  (PREADY),
        .prdata_i  (PRDATA),
        .pslverr_i (PSLVERR)
    );

    assign unused_rdata = ^x_rdata;

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign ovf_seen = ovf_q;
    assign err      = err_q;

endmodule

// File: doc/timer_ctrl_seq.md
TIMER_CTRL_SEQ -- requirements
Module: timer_ctrl_seq

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width.
REQ-002 SHALL have parameter TIMER_BASE, default 12'h000, timer register block base on PADDR.
REQ-003 SHALL have parameter POLL_GAP, default 8, idle PCLK cycles between TSR polls (range 1..255).
REQ-004 SHALL have parameter MAX_POLLS, default 16'd1024, TSR poll limit, used only with the timeout feature.
REQ-005 PCLK  in  1  sole clock; all logic on rising edge.
REQ-006 PRESET  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request, honoured only in IDLE.
REQ-008 init_value  in  8  TDR load value, captured when start is accepted.
REQ-009 abort  in  1  level; stops the sequence at the next transfer boundary.
REQ-010 busy  out  1  high from the cycle after start is accepted until DONE exits.
REQ-011 done  out  1  one-cycle pulse at sequence end.
REQ-012 ovf_seen  out  1  sticky; overflow observed in the last run.
REQ-013 err  out  2  00 ok, 01 PSLVERR, 10 timeout; valid with done.
REQ-014 PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
REQ-015 PADDR  out  APB_ADDR_WIDTH  TIMER_BASE + register offset.
REQ-016 PWDATA  out  32  write data, upper 24 bits zero.
REQ-017 PRDATA  in  8;  PREADY  in  1;  PSLVERR  in  1  timer slave response.

Function
REQ-018 Register offsets SHALL be TDR=0, TCR=1, TSR=2; TCR bit7 = load, TCR bit4 = enable; TSR bit0 = overflow.
REQ-019 States SHALL be IDLE, WR_TDR, WR_TCR_LD, WR_TCR_EN, GAP, RD_TSR, CLR_TSR, DONE.
REQ-020 Sequence SHALL be: write TDR=init_value, write TCR=8'h80, write TCR=8'h10, then loop (GAP, RD_TSR) until TSR[0]=1, then write TSR=8'h00, then DONE.
REQ-021 Each transfer SHALL be one SETUP cycle (PSEL=1, PENABLE=0) followed by ACCESS (PENABLE=1) held until PREADY=1; PADDR/PWRITE/PWDATA stable across both.
REQ-022 PSEL and PENABLE SHALL be 0 in the cycle after a completed transfer; back-to-back transfers are not allowed.
REQ-023 PRDATA SHALL be sampled only on the ACCESS cycle with PREADY=1.
REQ-024 A completed transfer with PSLVERR=1 SHALL go to DONE with err=01, with no further transfers.
REQ-025 GAP SHALL last exactly POLL_GAP cycles with PSEL=0.
REQ-026 ovf_seen SHALL clear when start is accepted and set on the RD_TSR completion that returns TSR[0]=1.
REQ-027 DONE SHALL last one cycle: done=1, then IDLE; busy drops in the IDLE cycle.
REQ-028 If start arrives while busy, the sequence SHALL ignore it without side effect.
REQ-029 If abort=1 in GAP or IDLE-to-setup, the block SHALL go to IDLE with no done pulse. During an APB access, abort SHALL be held until PREADY completes the transfer, then the block goes to IDLE.

Reset
REQ-030 On PRESET=1 the block SHALL enter IDLE next edge, including mid-transfer. All outputs SHALL be 0: busy, done, ovf_seen, err, PSEL, PENABLE, PWRITE, PADDR, PWDATA.

Configuration
REQ-031 With TMR_SEQ_TIMEOUT_EN defined, a 16-bit poll counter SHALL count RD_TSR completions; reaching MAX_POLLS without overflow SHALL go to DONE with err=10, skipping CLR_TSR.
REQ-032 Without TMR_SEQ_TIMEOUT_EN, the counter and MAX_POLLS logic SHALL be absent, polling SHALL be unbounded (exit only via overflow, PSLVERR, abort or reset), and err=10 SHALL never occur.

Structure
REQ-033 Package tmr_seq_pkg SHALL hold the state enum, register offsets, TCR/TSR bit positions and the err code constants.
REQ-034 Sub-module tmr_apb_xfer SHALL implement the single-transfer SETUP/ACCESS engine (req/addr/wdata/write in; ack/rdata/slverr out), and the FSM SHALL drive it.

Verification
REQ-035 start with init_value=8'h64, PREADY tied 1 -> writes TDR=0x64, TCR=0x80, TCR=0x10 on PADDR 0,1,1, each 2 cycles with an idle cycle between.
REQ-036 Slave returns TSR=0x00 three times then 0x01 -> 4 reads spaced POLL_GAP=8 cycles apart, then write TSR=0x00, done=1, err=00, ovf_seen=1.
REQ-037 PREADY low 3 cycles during the TCR=0x10 ACCESS -> PENABLE held 4 cycles with stable PADDR/PWDATA, then the sequence continues.
REQ-038 PSLVERR=1 on the TDR write -> done=1, err=01, no TCR access issued.
REQ-039 Timeout build, MAX_POLLS=4, TSR always 0x00 -> 4 reads then done=1, err=10, no TSR clear; abort in GAP -> IDLE, no done.
REQ-040 PRESET during the RD_TSR ACCESS -> next cycle all outputs are 0 and the state is IDLE; a subsequent start runs the full sequence.
